pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB). It produces the global stall, the IF/ID flush and the ID/EX bubble, and the operand-forwarding selects for the EX stage. It also sequences multi-cycle divide instructions. It observes register addresses and control bits from the ID, EX, MEM and WB pipeline registers and drives the shared stall line and the flush inputs of the PC module and the stage registers.

Parameters:
DIV_CYCLES, 16, total stall cycles a divide holds EX (legal range 1..255)
REG_AW, 8, register-address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_a_reg  in  REG_AW  source A address of instruction in ID
id_b_reg  in  REG_AW  source B address of instruction in ID
id_uses_b  in  1  ID instruction reads B (0 for immediate forms)
ex_c_reg  in  REG_AW  destination of instruction in EX
ex_rwe  in  1  EX instruction writes register file
ex_load  in  1  EX instruction is a memory load (Mem & !Store)
ex_div  in  1  EX instruction is a divide
ex_jump_taken  in  1  branch/jump resolved taken in EX (shouldJump)
mem_c_reg  in  REG_AW  destination in MEM
mem_rwe  in  1  MEM instruction writes register file
wb_c_reg  in  REG_AW  destination in WB
wb_rwe  in  1  WB instruction writes register file
stall  out  1  freeze PC, IF/ID and ID/EX
flush_if_id  out  1  replace IF/ID contents with NOP
bubble_id_ex  out  1  insert NOP into ID/EX
fwd_a_sel  out  2  0=regfile, 1=EX/MEM result, 2=MEM/WB data
fwd_b_sel  out  2  same encoding for operand B
div_start  out  1  one-cycle pulse to the divider
stall_cycles  out  16  saturating count of cycles with stall=1

Behaviour:
- Reset: while rst_n=0, at every clock: state=RUN, div counter=0, stall_cycles=0. All outputs read 0 during reset and in the first cycle after rst_n rises.
- States: RUN, DIV_WAIT, FLUSH2. A 2-bit state register and an 8-bit div counter.
- Forwarding (combinational, every state) for operand A:
  - fwd_a_sel=1 if mem_rwe && mem_c_reg==id_a_reg.
  - Else fwd_a_sel=2 if wb_rwe && wb_c_reg==id_a_reg.
  - Else fwd_a_sel=0.
  - Operand B uses the same rules with id_b_reg, and fwd_b_sel=0 when id_uses_b=0.
  - No register is hardwired; address 0 forwards like any other.
- Load-use (RUN): if ex_load && ex_rwe && ex_c_reg matches id_a_reg, or matches id_b_reg with id_uses_b=1:
  - stall=1 and bubble_id_ex=1 for one cycle, combinationally.
  - No state change.
- Jump (RUN): if ex_jump_taken:
  - flush_if_id=1 and bubble_id_ex=1 this cycle, stall=0.
  - Next state FLUSH2.
- FLUSH2: flush_if_id=1 for one cycle to squash the word already fetched by the synchronous instruction RAM, then go to RUN. Hazard and divide detection are suppressed in this state.
- Divide (RUN): if ex_div:
  - This cycle: stall=1, div_start=1, counter loaded with DIV_CYCLES-1, next state DIV_WAIT.
  - DIV_WAIT: stall=(counter!=0); counter decrements while nonzero.
  - When counter==0: stall=0, next state RUN. The divide advances this cycle, so ex_div is not re-sampled.
  - Total stall cycles = DIV_CYCLES. DIV_CYCLES=1 gives a single stall cycle.
- Priority in RUN: ex_jump_taken > ex_div > load-use. A taken jump suppresses div_start and the load-use stall.
- stall_cycles increments on each clock where stall=1 and saturates at 16'hFFFF.
- All outputs other than stall_cycles and the state/counter are combinational from state plus inputs. No additional latency.

Decomposition:
- Package it_hazard_pkg:
  - State enum (RUN, DIV_WAIT, FLUSH2).
  - Forward-select constants FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - REG_AW default.
- Sub-module it_fwd_unit: purely combinational forwarding-select logic, instantiated once per operand or once for both.
- The state machine, div counter and stall counter stay in the top module.

Test Plan:
- Reset: rst_n=0 for 3 cycles with ex_div=1 and ex_jump_taken=1 -> all outputs 0 during reset, no div_start, and stall_cycles=0 after release.
- Forwarding: mem_rwe=1, mem_c_reg=5, wb_rwe=1, wb_c_reg=5, id_a_reg=5 -> fwd_a_sel=1. Then mem_rwe=0 -> fwd_a_sel=2. Then id_uses_b=0 with id_b_reg=5 -> fwd_b_sel=0.
- Load-use: ex_load=1, ex_rwe=1, ex_c_reg=3, id_b_reg=3, id_uses_b=1 -> stall=1 and bubble_id_ex=1 for exactly one cycle. Same stimulus with id_uses_b=0 -> no stall.
- Divide with DIV_CYCLES=4: ex_div held high -> div_start pulses once, stall=1 for 4 consecutive cycles, stall=0 on the 5th cycle, and stall_cycles=4.
- Jump: ex_jump_taken=1 together with a load-use match -> stall=0, flush_if_id=1 and bubble_id_ex=1 for one cycle, then flush_if_id=1 for one more cycle; a div asserted in the FLUSH2 cycle is ignored.
- Saturation: force stall for 65,540 cycles via back-to-back divides -> stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/it_hazard_pkg.sv
// rtl/it_hazard_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Contents:
//   hz_state_t     controller state (RUN, DIV_WAIT, FLUSH2)
//   FWD_*          operand-forwarding select encodings
//   REG_AW_DEF     default register-address width
//   DIV_CYCLES_DEF default divide stall length

package it_hazard_pkg;

    localparam int REG_AW_DEF     = 8;
    localparam int DIV_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_FLUSH2   = 2'd2
    } hz_state_t;

    // Forwarding selects seen by the EX operand muxes
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline observation inputs and hazard control outputs
//
// Signals:
//   id_a_reg/id_b_reg/id_uses_b        sources of the instruction in ID
//   ex_c_reg/ex_rwe/ex_load/ex_div     destination and kind of the instruction in EX
//   ex_jump_taken                      branch/jump resolved taken in EX
//   mem_c_reg/mem_rwe, wb_c_reg/wb_rwe destinations further down the pipe
//   stall/flush_if_id/bubble_id_ex     pipeline control outputs
//   fwd_a_sel/fwd_b_sel                EX operand forwarding selects
//   div_start                          one-cycle divider kick
//   stall_cycles                       saturating stall counter
// Modports: master drives the pipeline observations, slave is the controller.

interface pipeline_hazard_ctrl_if
    import it_hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
);
    logic [REG_AW-1:0] id_a_reg;
    logic [REG_AW-1:0] id_b_reg;
    logic              id_uses_b;
    logic [REG_AW-1:0] ex_c_reg;
    logic              ex_rwe;
    logic              ex_load;
    logic              ex_div;
    logic              ex_jump_taken;
    logic [REG_AW-1:0] mem_c_reg;
    logic              mem_rwe;
    logic [REG_AW-1:0] wb_c_reg;
    logic              wb_rwe;

    logic              stall;
    logic              flush_if_id;
    logic              bubble_id_ex;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              div_start;
    logic [15:0]       stall_cycles;

    modport master (
        output id_a_reg, id_b_reg, id_uses_b,
        output ex_c_reg, ex_rwe, ex_load, ex_div, ex_jump_taken,
        output mem_c_reg, mem_rwe, wb_c_reg, wb_rwe,
        input  stall, flush_if_id, bubble_id_ex,
        input  fwd_a_sel, fwd_b_sel, div_start, stall_cycles
    );

    modport slave (
        input  id_a_reg, id_b_reg, id_uses_b,
        input  ex_c_reg, ex_rwe, ex_load, ex_div, ex_jump_taken,
        input  mem_c_reg, mem_rwe, wb_c_reg, wb_rwe,
        output stall, flush_if_id, bubble_id_ex,
        output fwd_a_sel, fwd_b_sel, div_start, stall_cycles
    );

endinterface

// File: rtl/it_fwd_unit.sv
// rtl/it_fwd_unit.sv - combinational forwarding select for one EX operand
//
// Ports:
//   i_src_reg   source register address read by the ID instruction
//   i_src_used  operand is actually read (0 for immediate forms)
//   i_mem_c_reg/i_mem_rwe  destination and write enable in MEM
//   i_wb_c_reg/i_wb_rwe    destination and write enable in WB
//   o_sel       FWD_RF / FWD_EXMEM / FWD_MEMWB

module it_fwd_unit
    import it_hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_src_reg,
    input  logic              i_src_used,
    input  logic [REG_AW-1:0] i_mem_c_reg,
    input  logic              i_mem_rwe,
    input  logic [REG_AW-1:0] i_wb_c_reg,
    input  logic              i_wb_rwe,
    output logic [1:0]        o_sel
);

    logic w_hit_mem;
    logic w_hit_wb;

    // No hardwired zero register: address 0 forwards like any other.
    assign w_hit_mem = i_mem_rwe && (i_mem_c_reg == i_src_reg);
    assign w_hit_wb  = i_wb_rwe  && (i_wb_c_reg  == i_src_reg);

    always_comb begin
        o_sel = FWD_RF;
        if (i_src_used) begin
            // The younger producer (MEM) wins over the older one (WB).
            if (w_hit_mem) begin
                o_sel = FWD_EXMEM;
            end else if (w_hit_wb) begin
                o_sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/bubble, forwarding and divide sequencing for a 5-stage pipe
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   hz     pipeline_hazard_ctrl_if.slave: ID/EX/MEM/WB observations in,
//          stall, flush_if_id, bubble_id_ex, fwd_a_sel, fwd_b_sel,
//          div_start and stall_cycles out
// Parameters:
//   DIV_CYCLES  stall cycles a divide holds EX (1..255)
//   REG_AW      register-address width, must match the interface instance

module pipeline_hazard_ctrl
    import it_hazard_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int REG_AW     = REG_AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    // The RUN cycle that accepts the divide is the first stall cycle,
    // so the counter only has to cover the remaining DIV_CYCLES-1.
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    hz_state_t   r_state;
    hz_state_t   w_state_nxt;
    logic [7:0]  r_div_cnt;
    logic [7:0]  w_div_cnt_nxt;
    logic [15:0] r_stall_cycles;
    logic        r_out_en;

    logic        w_en;
    logic        w_load_use;
    logic        w_stall;
    logic        w_flush;
    logic        w_bubble;
    logic        w_div_start;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // Outputs stay quiet while in reset and for the first cycle after
    // release, so a stray ex_div/ex_jump_taken there cannot start anything.
    assign w_en = r_out_en && rst_n;

    assign w_load_use = hz.ex_load && hz.ex_rwe &&
                        ((hz.ex_c_reg == hz.id_a_reg) ||
                         (hz.id_uses_b && (hz.ex_c_reg == hz.id_b_reg)));

    it_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .i_src_reg   (hz.id_a_reg),
        .i_src_used  (1'b1),
        .i_mem_c_reg (hz.mem_c_reg),
        .i_mem_rwe   (hz.mem_rwe),
        .i_wb_c_reg  (hz.wb_c_reg),
        .i_wb_rwe    (hz.wb_rwe),
        .o_sel       (w_fwd_a)
    );

    it_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .i_src_reg   (hz.id_b_reg),
        .i_src_used  (hz.id_uses_b),
        .i_mem_c_reg (hz.mem_c_reg),
        .i_mem_rwe   (hz.mem_rwe),
        .i_wb_c_reg  (hz.wb_c_reg),
        .i_wb_rwe    (hz.wb_rwe),
        .o_sel       (w_fwd_b)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_stall       = 1'b0;
        w_flush       = 1'b0;
        w_bubble      = 1'b0;
        w_div_start   = 1'b0;
        if (w_en) begin
            case (r_state)
                ST_RUN: begin
                    // Jump beats divide beats load-use.
                    if (hz.ex_jump_taken) begin
                        w_flush     = 1'b1;
                        w_bubble    = 1'b1;
                        w_state_nxt = ST_FLUSH2;
                    end else if (hz.ex_div) begin
                        w_stall       = 1'b1;
                        w_div_start   = 1'b1;
                        w_div_cnt_nxt = DIV_LOAD;
                        w_state_nxt   = ST_DIV_WAIT;
                    end else if (w_load_use) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                ST_DIV_WAIT: begin
                    // On the zero cycle the divide leaves EX, so ex_div
                    // is not looked at again here.
                    if (r_div_cnt != 8'd0) begin
                        w_stall       = 1'b1;
                        w_div_cnt_nxt = r_div_cnt - 8'd1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FLUSH2: begin
                    // Squash the word the synchronous instruction RAM
                    // already returned for the wrong-path PC.
                    w_flush     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt   = ST_RUN;
                    w_div_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_div_cnt      <= 8'd0;
            r_stall_cycles <= 16'd0;
            r_out_en       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_out_en  <= 1'b1;
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign hz.stall        = w_stall;
    assign hz.flush_if_id  = w_flush;
    assign hz.bubble_id_ex = w_bubble;
    assign hz.div_start    = w_div_start;
    assign hz.fwd_a_sel    = w_en ? w_fwd_a : FWD_RF;
    assign hz.fwd_b_sel    = w_en ? w_fwd_b : FWD_RF;
    assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;
    import it_hazard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(8)) hz ();
    pipeline_hazard_ctrl_if #(.REG_AW(8)) hz2 ();

    pipeline_hazard_ctrl #(.DIV_CYCLES(4), .REG_AW(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    // Long divides held back-to-back drive the stall counter into saturation.
    pipeline_hazard_ctrl #(.DIV_CYCLES(255), .REG_AW(8)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz2)
    );

    typedef struct {
        string       name;
        logic [23:0] vec;
    } exp_t;

    exp_t        exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [23:0] act;

    // {stall, flush, bubble, fwd_a, fwd_b, div_start, stall_cycles}
    function automatic logic [23:0] pack_o(logic st, logic fl, logic bu, logic [1:0] fa,
                                           logic [1:0] fb, logic ds, logic [15:0] sc);
        return {st, fl, bu, fa, fb, ds, sc};
    endfunction

    task automatic expect_o(string nm, logic st, logic fl, logic bu, logic [1:0] fa,
                            logic [1:0] fb, logic ds, logic [15:0] sc);
        exp_t e;
        e.name = nm;
        e.vec  = pack_o(st, fl, bu, fa, fb, ds, sc);
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the outputs are valid, so each queued
    // expectation is consumed on the falling edge of its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = pack_o(hz.stall, hz.flush_if_id, hz.bubble_id_ex, hz.fwd_a_sel,
                         hz.fwd_b_sel, hz.div_start, hz.stall_cycles);
            n_total++;
            if (act !== e.vec) begin
                n_bad++;
                $display("FAIL %s: got st=%0b fl=%0b bu=%0b fa=%0d fb=%0d ds=%0b sc=%0d want st=%0b fl=%0b bu=%0b fa=%0d fb=%0d ds=%0b sc=%0d",
                         e.name, act[23], act[22], act[21], act[20:19], act[18:17], act[16], act[15:0],
                         e.vec[23], e.vec[22], e.vec[21], e.vec[20:19], e.vec[18:17], e.vec[16], e.vec[15:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_a_reg      = '0;
        hz.id_b_reg      = '0;
        hz.id_uses_b     = 1'b0;
        hz.ex_c_reg      = '0;
        hz.ex_rwe        = 1'b0;
        hz.ex_load       = 1'b0;
        hz.ex_div        = 1'b0;
        hz.ex_jump_taken = 1'b0;
        hz.mem_c_reg     = '0;
        hz.mem_rwe       = 1'b0;
        hz.wb_c_reg      = '0;
        hz.wb_rwe        = 1'b0;
    endtask

    task automatic set_fwd(logic mrwe, logic [7:0] mc, logic wrwe, logic [7:0] wc,
                           logic [7:0] a, logic [7:0] b, logic ub);
        hz.mem_rwe   = mrwe;
        hz.mem_c_reg = mc;
        hz.wb_rwe    = wrwe;
        hz.wb_c_reg  = wc;
        hz.id_a_reg  = a;
        hz.id_b_reg  = b;
        hz.id_uses_b = ub;
    endtask

    task automatic set_ex(logic ld, logic rwe, logic [7:0] c, logic dv, logic jmp);
        hz.ex_load       = ld;
        hz.ex_rwe        = rwe;
        hz.ex_c_reg      = c;
        hz.ex_div        = dv;
        hz.ex_jump_taken = jmp;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        idle();
        hz.ex_div        = 1'b1;
        hz.ex_jump_taken = 1'b1;
        hz2.id_a_reg      = '0;
        hz2.id_b_reg      = '0;
        hz2.id_uses_b     = 1'b0;
        hz2.ex_c_reg      = '0;
        hz2.ex_rwe        = 1'b0;
        hz2.ex_load       = 1'b0;
        hz2.ex_div        = 1'b1;
        hz2.ex_jump_taken = 1'b0;
        hz2.mem_c_reg     = '0;
        hz2.mem_rwe       = 1'b0;
        hz2.wb_c_reg      = '0;
        hz2.wb_rwe        = 1'b0;

        // Reset with divide and jump requests pending
        repeat (3) begin
            tick();
            expect_o("reset", 0, 0, 0, 0, 0, 0, 16'd0);
        end
        tick(); rst_n = 1'b1;
        expect_o("rst_release", 0, 0, 0, 0, 0, 0, 16'd0);
        tick(); idle();
        expect_o("post_reset", 0, 0, 0, 0, 0, 0, 16'd0);

        // Forwarding
        tick(); idle(); set_fwd(1, 8'd5, 1, 8'd5, 8'd5, 8'd7, 1);
        expect_o("fwd_mem_prio", 0, 0, 0, 2'd1, 2'd0, 0, 16'd0);
        tick(); hz.mem_rwe = 1'b0;
        expect_o("fwd_wb", 0, 0, 0, 2'd2, 2'd0, 0, 16'd0);
        tick(); hz.id_b_reg = 8'd5; hz.id_uses_b = 1'b0;
        expect_o("fwd_b_unused", 0, 0, 0, 2'd2, 2'd0, 0, 16'd0);
        tick(); hz.id_uses_b = 1'b1;
        expect_o("fwd_b_wb", 0, 0, 0, 2'd2, 2'd2, 0, 16'd0);
        tick(); idle(); set_fwd(1, 8'd0, 0, 8'd0, 8'd0, 8'd0, 1);
        expect_o("fwd_reg0", 0, 0, 0, 2'd1, 2'd1, 0, 16'd0);

        // Divide, 4 stall cycles, ex_div held
        tick(); idle(); hz.ex_div = 1'b1;
        expect_o("div_start", 1, 0, 0, 0, 0, 1, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_o("div_wait", 1, 0, 0, 0, 0, 0, 16'(i));
        end
        tick();
        expect_o("div_done", 0, 0, 0, 0, 0, 0, 16'd4);
        tick(); idle();
        expect_o("div_idle", 0, 0, 0, 0, 0, 0, 16'd4);

        // Load-use
        tick(); idle(); set_ex(1, 1, 8'd3, 0, 0);
        hz.id_a_reg = 8'd1; hz.id_b_reg = 8'd3; hz.id_uses_b = 1'b1;
        expect_o("ldu_b", 1, 0, 1, 0, 0, 0, 16'd4);
        tick(); idle();
        expect_o("ldu_b_released", 0, 0, 0, 0, 0, 0, 16'd5);
        tick(); set_ex(1, 1, 8'd3, 0, 0); hz.id_b_reg = 8'd3; hz.id_uses_b = 1'b0;
        expect_o("ldu_b_unused", 0, 0, 0, 0, 0, 0, 16'd5);
        tick(); hz.id_uses_b = 1'b1; hz.ex_rwe = 1'b0;
        expect_o("ldu_no_rwe", 0, 0, 0, 0, 0, 0, 16'd5);
        tick(); hz.ex_rwe = 1'b1; hz.id_uses_b = 1'b0; hz.id_a_reg = 8'd3;
        expect_o("ldu_a", 1, 0, 1, 0, 0, 0, 16'd5);
        tick(); idle();
        expect_o("ldu_a_released", 0, 0, 0, 0, 0, 0, 16'd6);

        // Jump with load-use match and divide pending
        tick(); set_ex(1, 1, 8'd3, 1, 1); hz.id_b_reg = 8'd3; hz.id_uses_b = 1'b1;
        expect_o("jump", 0, 1, 1, 0, 0, 0, 16'd6);
        tick(); hz.ex_jump_taken = 1'b0;
        expect_o("flush2_div_ignored", 0, 1, 0, 0, 0, 0, 16'd6);
        tick(); idle();
        expect_o("after_flush", 0, 0, 0, 0, 0, 0, 16'd6);
        tick();
        expect_o("no_div_wait", 0, 0, 0, 0, 0, 0, 16'd6);

        for (k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge clk);
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        // Saturation on the long-divide instance
        for (k = 0; k < 70000 && hz2.stall_cycles !== 16'hFFFF; k++) tick();
        n_total++;
        if (hz2.stall_cycles !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_reach: got %h want ffff", hz2.stall_cycles);
        end
        repeat (600) tick();
        n_total++;
        if (hz2.stall_cycles !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold: got %h want ffff", hz2.stall_cycles);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
